// File: rtl/ucdp_clk_gate_ctrl.sv
// ============================================================================
// ucdp_clk_gate_ctrl
//   Multi-channel idle-timeout clock gating with req/ack wake and DFT bypass.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module ucdp_clk_gate_ctrl #(
  parameter int NUM_CH = 4,
  parameter int IDLE_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_an_i,
  input  logic              test_en_i,
  input  logic [IDLE_W-1:0] idle_thr_i,
  input  logic [NUM_CH-1:0] busy_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] force_on_i,
  output logic [NUM_CH-1:0] ack_o,
  output logic [NUM_CH-1:0] gated_o,
  output logic [NUM_CH-1:0] clk_o
);

  typedef enum logic [1:0] {
    ST_WAKE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_en;
    logic              w_en_nxt;
    logic              r_ack;
    logic              w_ack_nxt;
    logic              r_gated;
    logic              w_gated_nxt;
    logic [IDLE_W-1:0] r_cnt;
    logic [IDLE_W-1:0] w_cnt_nxt;
    logic              r_latch;
    logic              w_act;

    assign w_act = busy_i[gi] | req_i[gi] | force_on_i[gi];

    always_comb begin
      w_state_nxt = r_state;
      w_en_nxt    = r_en;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = r_ack;
      w_gated_nxt = r_gated;
      case (r_state)
        ST_WAKE: begin
          // Unconditional: one full settle cycle before ack.
          w_state_nxt = ST_RUN;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_gated_nxt = 1'b0;
        end
        ST_RUN: begin
          w_en_nxt = 1'b1;
          if (w_act) begin
            w_cnt_nxt = '0;
          end else if (r_cnt >= idle_thr_i) begin
            w_state_nxt = ST_OFF;
            w_en_nxt    = 1'b0;
            w_ack_nxt   = 1'b0;
            w_gated_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + IDLE_W'(1);
          end
        end
        ST_OFF: begin
          w_en_nxt  = 1'b0;
          w_cnt_nxt = '0;
          if (w_act) begin
            w_state_nxt = ST_WAKE;
            w_en_nxt    = 1'b1;
            w_gated_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ST_WAKE;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b0;
          w_gated_nxt = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
        r_state <= ST_WAKE;
        r_en    <= 1'b1;
        r_cnt   <= '0;
        r_ack   <= 1'b0;
        r_gated <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_en    <= w_en_nxt;
        r_cnt   <= w_cnt_nxt;
        r_ack   <= w_ack_nxt;
        r_gated <= w_gated_nxt;
      end
    end

    // Low-transparent latch: enable can only change while clk_i is low.
    always_latch begin
      if (!rst_an_i) begin
        r_latch <= 1'b1;
      end else if (!clk_i) begin
        r_latch <= r_en | test_en_i;
      end
    end

    assign clk_o[gi]   = clk_i & r_latch;
    assign ack_o[gi]   = r_ack;
    assign gated_o[gi] = r_gated;

`ifdef SIM
`ifndef SYN
    logic r_seen_pos;
    logic r_chk_arm;
    logic r_warned;

    always @(posedge clk_i) r_seen_pos <= 1'b1;
    always @(negedge clk_i) if (r_seen_pos === 1'b1) r_chk_arm <= 1'b1;

    always @(clk_i or clk_o[gi]) begin
      if (r_chk_arm === 1'b1 && r_warned !== 1'b1 && clk_i === 1'b1 && $isunknown(clk_o[gi])) begin
        $warning("ucdp_clk_gate_ctrl: clk_o[%0d] is X while clk_i is high", gi);
        r_warned <= 1'b1;
      end
    end
`endif
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_ucdp_clk_gate_ctrl.sv
// Scoreboard bench for ucdp_clk_gate_ctrl: directed vectors, queued expectations,
// pulse counting on clk_o and a minimum high-phase width check.
`default_nettype none

module tb_ucdp_clk_gate_ctrl;
  localparam int NC   = 4;
  localparam int IW   = 4;
  localparam int HALF = 5;

  logic          clk = 1'b0;
  logic          rst_an;
  logic          test_en;
  logic [IW-1:0] thr;
  logic [NC-1:0] busy, req, force_on;
  logic [NC-1:0] ack_o, gated_o, clk_o;

  ucdp_clk_gate_ctrl #(.NUM_CH(NC), .IDLE_W(IW)) dut (
    .clk_i      (clk),
    .rst_an_i   (rst_an),
    .test_en_i  (test_en),
    .idle_thr_i (thr),
    .busy_i     (busy),
    .req_i      (req),
    .force_on_i (force_on),
    .ack_o      (ack_o),
    .gated_o    (gated_o),
    .clk_o      (clk_o)
  );

  always #HALF clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pcnt  [NC];
  int pbase [NC];

  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: ack/gated check, 1: mark pulse window, 2: check pulse counts and re-mark
  typedef struct {
    int                 kind;
    int                 cyc;
    logic [NC-1:0]      ack;
    logic [NC-1:0]      gated;
    logic [NC-1:0][7:0] p;
    string              name;
  } item_t;

  item_t q[$];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_st(input int n, input logic [NC-1:0] a, input logic [NC-1:0] g, input string nm);
    item_t it;
    it.kind = 0; it.cyc = cyc + n; it.ack = a; it.gated = g; it.p = '0; it.name = nm;
    q.push_back(it);
  endtask

  task automatic pmark(input int n);
    item_t it;
    it.kind = 1; it.cyc = cyc + n; it.ack = '0; it.gated = '0; it.p = '0; it.name = "mark";
    q.push_back(it);
  endtask

  task automatic pchk(input int n, input logic [NC-1:0][7:0] p, input string nm);
    item_t it;
    it.kind = 2; it.cyc = cyc + n; it.ack = '0; it.gated = '0; it.p = p; it.name = nm;
    q.push_back(it);
  endtask

  // Pulse counter: one count per clk_i high phase in which clk_o is high.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NC; i++) if (clk_o[i] === 1'b1) pcnt[i] = pcnt[i] + 1;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    item_t              it;
    logic [NC-1:0][7:0] pa;
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      if (it.kind == 0) begin
        checks++;
        if (ack_o !== it.ack || gated_o !== it.gated) begin
          failures++;
          $display("FAIL %s cyc=%0d: got ack_o=%b gated_o=%b, expected ack_o=%b gated_o=%b",
                   it.name, cyc, ack_o, gated_o, it.ack, it.gated);
        end
      end else begin
        if (it.kind == 2) begin
          for (int i = 0; i < NC; i++) pa[i] = 8'(pcnt[i] - pbase[i]);
          checks++;
          if (pa !== it.p) begin
            failures++;
            $display("FAIL %s cyc=%0d: got pulses=%h, expected pulses=%h", it.name, cyc, pa, it.p);
          end
        end
        for (int i = 0; i < NC; i++) pbase[i] = pcnt[i];
      end
    end
  end

  // No clk_o high phase may be shorter than clk_i's high phase.
  for (genvar gi = 0; gi < NC; gi++) begin : g_width
    time t_rise;
    bit  seen = 1'b0;
    always @(posedge clk_o[gi]) begin
      t_rise = $time;
      seen   = 1'b1;
    end
    always @(negedge clk_o[gi]) begin
      if (seen) begin
        checks++;
        if ($time - t_rise < HALF) begin
          failures++;
          $display("FAIL glitch ch%0d: high width=%0t, required>=%0d", gi, $time - t_rise, HALF);
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_an = 1'b0; test_en = 1'b0; thr = 4'd3;
    busy = '0; req = '0; force_on = '0;

    // Reset: outputs low, clk_o follows clk_i
    @(negedge clk);
    exp_st(0, 4'h0, 4'h0, "reset_outputs");
    pmark(0);
    pchk(3, {8'd3, 8'd3, 8'd3, 8'd3}, "reset_clk_follow");
    step(3);

    // Release, thr=3: ack after first edge, gate after 4 idle cycles, 5 pulses
    rst_an = 1'b1;
    exp_st(1, 4'hF, 4'h0, "release_ack");
    exp_st(4, 4'hF, 4'h0, "idle_not_yet");
    exp_st(5, 4'h0, 4'hF, "idle_gate");
    pchk(5, {8'd5, 8'd5, 8'd5, 8'd5}, "pulses_after_release");
    pchk(8, {8'd0, 8'd0, 8'd0, 8'd0}, "gated_flat");
    step(8);

    // Wake handshake on channel 1
    req = 4'b0010;
    pmark(0);
    exp_st(1, 4'b0000, 4'b1101, "wake_gated_clear");
    exp_st(2, 4'b0010, 4'b1101, "wake_ack");
    pchk(2, {8'd0, 8'd0, 8'd1, 8'd0}, "wake_pulse");
    step(2);
    req = '0;
    exp_st(3, 4'b0010, 4'b1101, "ch1_idle_hold");
    exp_st(4, 4'b0000, 4'hF, "ch1_gate");
    step(4);

    // thr=0: a single idle cycle gates channel 0
    thr  = 4'd0;
    busy = 4'b0001;
    exp_st(2, 4'b0001, 4'b1110, "thr0_ack");
    step(2);
    busy = '0;
    exp_st(1, 4'b0000, 4'hF, "thr0_gate");
    step(1);

    // busy on the threshold cycle keeps channel 2 running and restarts cnt
    thr = 4'd3;
    req = 4'b0100;
    step(2);
    exp_st(0, 4'b0100, 4'b1011, "ch2_ack");
    req = '0;
    step(3);
    busy = 4'b0100;
    exp_st(1, 4'b0100, 4'b1011, "busy_on_thr");
    step(1);
    busy = '0;
    exp_st(3, 4'b0100, 4'b1011, "cnt_restart");
    exp_st(4, 4'b0000, 4'hF, "restart_gate");
    step(4);

    // thr lowered from 15 to 2 with cnt=7 on channel 3
    thr = 4'd15;
    req = 4'b1000;
    step(2);
    req = '0;
    step(7);
    thr = 4'd2;
    exp_st(0, 4'b1000, 4'b0111, "thr15_hold");
    exp_st(1, 4'b0000, 4'hF, "thr_lower_gate");
    step(1);

    // DFT bypass: all clocks toggle, gated flags stay set
    test_en = 1'b1;
    pmark(0);
    pchk(4, {8'd4, 8'd4, 8'd4, 8'd4}, "dft_toggle");
    exp_st(4, 4'h0, 4'hF, "dft_gated_flag");
    step(4);
    test_en = 1'b0;
    pchk(3, {8'd0, 8'd0, 8'd0, 8'd0}, "dft_off_flat");
    step(3);

    // force_on for 100 cycles on channel 0
    thr      = 4'd3;
    force_on = 4'b0001;
    step(2);
    pmark(0);
    exp_st(100, 4'b0001, 4'b1110, "force_100");
    pchk(100, {8'd0, 8'd0, 8'd0, 8'd100}, "force_pulses");
    step(100);
    force_on = '0;
    exp_st(3, 4'b0001, 4'b1110, "force_rel_hold");
    exp_st(4, 4'b0000, 4'hF, "force_rel_gate");
    step(4);

    // Random mid-phase toggling of req/busy (width monitor active)
    for (int k = 0; k < 60; k++) begin
      #($urandom_range(1, 9));
      req  = NC'($urandom);
      busy = NC'($urandom);
    end
    @(negedge clk);
    req = '0; busy = '0;
    step(10);
    exp_st(0, 4'h0, 4'hF, "rand_settle");

    // Reset asserted with channel 0 in WAKE and the rest OFF
    req = 4'b0001;
    step(1);
    rst_an = 1'b0;
    exp_st(0, 4'h0, 4'h0, "midrst_outputs");
    pmark(0);
    pchk(3, {8'd3, 8'd3, 8'd3, 8'd3}, "midrst_follow");
    step(3);
    req    = '0;
    rst_an = 1'b1;
    exp_st(1, 4'hF, 4'h0, "midrst_release");
    step(1);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d, required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ucdp_clk_gate_ctrl.md
# ucdp_clk_gate_ctrl

Multi-channel clock gating controller with integrated latch-based gates. One free-running clock is fanned out into `NUM_CH` independently gated clocks. Each channel turns its own clock off automatically after a programmable number of idle cycles and turns it back on through a req/ack wake handshake. The block sits between the clock root of a subsystem and its peripheral clock domains, and also provides a DFT bypass.

## Interface

Parameters:
- `NUM_CH`, default 4: number of gated clock channels (1..32).
- `IDLE_W`, default 4: width of the idle threshold and of the per-channel idle counter (1..16).

Ports:
- `clk_i`  in  1  free-running source clock. This is the block's one clock.
- `rst_an_i`  in  1  reset, asynchronous, active-low.
- `test_en_i`  in  1  DFT bypass; forces every gate open.
- `idle_thr_i`  in  `IDLE_W`  idle threshold shared by all channels; quasi-static.
- `busy_i`  in  `NUM_CH`  per-channel consumer busy.
- `req_i`  in  `NUM_CH`  per-channel wake request; level.
- `force_on_i`  in  `NUM_CH`  per-channel keep-clock-on.
- `ack_o`  out  `NUM_CH`  per-channel clock running and stable; registered.
- `gated_o`  out  `NUM_CH`  per-channel clock is gated off; registered.
- `clk_o`  out  `NUM_CH`  gated clocks.

## Operation

- **Per-channel state and storage.** Each channel has an FSM with states WAKE, RUN and OFF. It also has an enable flop `en_r`, an idle counter `cnt` (`IDLE_W` bits) and an output latch.
- **Channel active.** `act = busy_i | req_i | force_on_i`.
- **Gate.**
  - The latch is transparent while `clk_i == 0` and captures `en_r | test_en_i`.
  - `clk_o = clk_i & latch`.
  - The gate never produces glitches or truncated high phases.
- **Reset (async, while `rst_an_i == 0`).**
  - FSM = WAKE, `en_r = 1`, latch forced to 1, `cnt = 0`.
  - `ack_o = 0`, `gated_o = 0`.
  - `clk_o` follows `clk_i` during reset.
- **WAKE.**
  - `en_r = 1`, `cnt = 0`.
  - Next edge: go to RUN and set `ack_o = 1`. This is unconditional; it gives one full settle cycle.
- **RUN.**
  - `en_r = 1`.
  - If `act`: `cnt <= 0`.
  - Else, if `cnt >= idle_thr_i`: go to OFF, `en_r <= 0`, `ack_o <= 0`, `gated_o <= 1`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`. The counter cannot wrap, because it leaves RUN at the threshold.
  - Idle cycles before gating = `idle_thr_i + 1`. Threshold 0 means the clock gates at the first idle edge.
- **OFF.**
  - `en_r = 0`.
  - If `act`: go to WAKE, `en_r <= 1`, `gated_o <= 0`.
  - `busy_i` rising while OFF is treated as a wake and is not an error.
- **Handshake.**
  - The requester raises `req_i` and holds it until it sees `ack_o = 1`.
  - `ack_o` stays high for as long as the channel is in RUN.
  - After `ack_o` rises, the requester may drop `req_i`. Dropping `req_i` before ack does not abort a wake already in progress (WAKE always completes into RUN).
- **Threshold change.** Lowering `idle_thr_i` below the current `cnt` gates at the next idle edge, because the comparison is `>=`.
- **`test_en_i`.** Affects only the latch input. FSM, `ack_o` and `gated_o` behave as in functional mode.
- **Channel independence.** Channels share only `clk_i`, `rst_an_i`, `test_en_i` and `idle_thr_i`.
- **Simulation check (SIM and not SYN only).** Per channel, print one warning if `clk_o` is X while `clk_i` is 1. The check is suppressed until the first posedge and the following negedge after time 0.

## Timing

- **Gate-off latency.** The last busy cycle is n.
  - The idle-threshold edge is at the end of cycle n+1+thr. At that edge `en_r` falls and `ack_o` falls.
  - The first suppressed `clk_o` high phase is in the following cycle.
- **Wake latency.** `req_i` rises in cycle n, sampled at edge n, with the channel in OFF.
  - `en_r` rises after edge n, and `clk_o` pulses from cycle n+1.
  - `ack_o` = 1 after edge n+1: 2 cycles from request to ack.
- **Request while RUN.** `ack_o` is already 1, so there is zero added latency. `cnt` clears at the next edge.
- **Simultaneous events.** `act` in the same cycle that `cnt` reaches the threshold keeps the channel in RUN; activity wins.
- **Reset release.** `ack_o` = 1 after the first posedge following deassertion of `rst_an_i`.
- **Reset mid-wake or mid-off.** `clk_o` resumes immediately when reset asserts, because the latch is forced to 1. The channel restarts in WAKE.
- **Timing constraints.** The path `en_r` → latch must meet half-cycle timing. `clk_o` must be constrained as a generated clock.

## Test plan

- **Reset and idle gating.** Reset, thr=3, all inputs 0 → `ack_o` = 1 after the first edge. After 4 idle cycles `gated_o` = 1, `ack_o` = 0 and `clk_o` is flat low; a cycle count confirms exactly 5 pulses after reset release.
- **Wake handshake.** Channel 1 in OFF, `req_i[1]` raised → `clk_o[1]` pulses from the next cycle and `ack_o[1]` = 1 two edges after the request. Channels 0, 2 and 3 stay gated.
- **Threshold edge cases.**
  - thr=0: one idle cycle gates the clock.
  - `busy_i` asserted exactly on the threshold cycle: no gating, and `cnt` restarts.
  - thr lowered from 15 to 2 while `cnt` = 7: gating at the next idle edge.
- **Force and DFT.**
  - `force_on_i` held for 100 cycles: never gated.
  - `test_en_i` = 1 with all channels OFF: every `clk_o` toggles while `gated_o` remains 1.
- **Glitch-free switching.** `req_i` and `busy_i` are randomly toggled mid-phase → no `clk_o` high pulse shorter than `clk_i`'s high phase. The X-warning fires zero times.
- **Reset mid-operation.** Assert `rst_an_i` in OFF and in WAKE → `clk_o` follows `clk_i` immediately, `ack_o` = 0 and `gated_o` = 0. After release, `ack_o` = 1 after one edge.
